result_frame_tx: RTL and testbench
==================================

Name: result_frame_tx

Overview:
Transmit-side framer for the matrix multiplier's UART link. It snapshots the flattened result matrix on a start pulse and streams one response frame through the uart_tx start/busy handshake: a size byte, the size×size elements in row-major order, then an XOR checksum. It sits between matrix_mult_parallel_flat/control_unit and uart_tx, clocked on the baud-domain clock. It replaces the ad-hoc result_index/result_byte logic in the top level.

Parameters:
MAX_SIZE, 10, maximum matrix dimension; result bus holds MAX_SIZE*MAX_SIZE elements
DATA_WIDTH, 8, bits per element (must be 8 in this revision; one element per UART byte)
SEND_CHECKSUM, 1, 1 = append checksum byte; 0 = frame ends after last element

Ports:
clk  input  1  baud-domain clock (bclk in top)
rst  input  1  reset, asynchronous, active-high
start  input  1  one-cycle request to send a frame (from control_unit on SEND_RESULT entry)
matrix_size  input  4  N, dimension of the result matrix
result  input  MAX_SIZE*MAX_SIZE*DATA_WIDTH  flattened C; element (r,c) at bits [(r*MAX_SIZE+c)*8 +: 8]
tx_busy  input  1  uart_tx busy
tx_start  output  1  one-cycle pulse to uart_tx
tx_data  output  8  byte presented to uart_tx; stable from tx_start until tx_busy falls
busy  output  1  high from accepted start until done
done  output  1  one-cycle pulse at end of frame or on rejected size
size_err  output  1  valid with done; 1 = frame rejected

Behaviour:
- Reset (async, immediate): state IDLE; tx_start=0, tx_data=0, busy=0, done=0, size_err=0; counters and checksum cleared. Reset mid-frame aborts at once. A partially sent byte is uart_tx's concern.
- Decided: one clock; reset is asynchronous and active-high (ports clk, rst).
- FSM states: IDLE, LOAD, SEND, WAIT_ACK, WAIT_DONE, FINISH.
- IDLE: on start=1, latch result and matrix_size into snapshot registers, set busy=1, go to LOAD. Later changes to result/matrix_size do not affect the frame.
- LOAD: if N==0 or N>MAX_SIZE, go to FINISH with size_err=1 and send no bytes. Otherwise select the header byte {4'b0,N}, clear the checksum, r=c=0, and go to SEND.
- SEND: assert tx_start for exactly one cycle with tx_data = current byte; fold the byte into the checksum (XOR); go to WAIT_ACK.
- WAIT_ACK: wait for tx_busy=1, then go to WAIT_DONE. If tx_busy is already 1 when entering, this is the ack.
- WAIT_DONE: wait for tx_busy=0. Then advance the byte pointer in order header → elements (c increments; at c==N-1, c=0 and r++) → checksum (if SEND_CHECKSUM). Go to SEND for the next byte, or to FINISH after the last byte.
- Checksum = XOR of the header and all element bytes. The checksum byte itself is not folded in.
- FINISH: done=1 for one cycle, busy=0 in the same cycle; size_err is held until the next accepted start; go to IDLE.
- Frame length = 1 + N*N + SEND_CHECKSUM bytes; N=10 gives 102 bytes.
- start while busy=1: ignored, not queued.
- start in the same cycle as FINISH: ignored; it is accepted only from IDLE.
- tx_busy high at the start pulse: the first tx_start waits. SEND is entered only when tx_busy==0; otherwise LOAD/WAIT_DONE holds.
- Minimum spacing between tx_start pulses is governed solely by tx_busy; there is no fixed latency.

Decomposition:
- Shared package (matrix_pkg): MAX_SIZE, DATA_WIDTH, frame constants (checksum enable), state encoding localparams. Reuse in control_unit.
- Sub-module: frame_byte_sel, a combinational mux from snapshot+(r,c)+phase to an 8-bit byte.
- No other sub-modules: the FSM and counters stay in result_frame_tx.

Test Plan:
- N=2; elements 0x11,0x22 at flat indices 0,1 and 0x33,0x44 at indices 10,11; uart_tx model with busy 10 cycles → bytes 02,11,22,33,44,46; one done, size_err=0.
- N=3; element(r,c)=r*16+c; result bus changed the cycle after start → bytes 03,00,01,02,10,11,12,20,21,22, then checksum = XOR of all; the snapshot is unaffected by the change.
- N=0, then N=11 → no tx_start; done pulses 2 cycles after start; size_err=1.
- Second start mid-frame (after byte 3) → ignored; frame completes with the correct count; exactly one done.
- tx_busy stuck high for 500 cycles before the first byte → no tx_start until it falls; then the normal frame follows.
- rst asserted asynchronously during byte 4 → outputs go to reset values without a clock edge; the next start sends a complete fresh frame.

Source files
------------

// File: rtl/matrix_pkg.sv
`default_nettype none
// ============================================================================
// Module      : matrix_pkg
// Description : Shared constants and types for the matrix multiplier link:
//               matrix geometry, response-frame options and the framer's
//               state / byte-phase encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package matrix_pkg;

  localparam int MATRIX_MAX_SIZE     = 10;
  localparam int MATRIX_DATA_WIDTH   = 8;
  localparam bit FRAME_SEND_CHECKSUM = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_SEND      = 3'd2,
    ST_WAIT_ACK  = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_FINISH    = 3'd5
  } frame_state_t;

  // Which part of the response frame the byte pointer is on.
  typedef enum logic [1:0] {
    PH_HEADER = 2'd0,
    PH_ELEM   = 2'd1,
    PH_CSUM   = 2'd2
  } frame_phase_t;

  // Total bytes on the wire for an n x n result.
  function automatic int frame_len(input int n, input bit csum);
    return 1 + n * n + (csum ? 1 : 0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/frame_byte_sel.sv
`default_nettype none
// ============================================================================
// Module      : frame_byte_sel
// Description : Combinational byte mux for the response frame. Picks the
//               header, element (row,col) of the snapshot, or the checksum.
// Ports       : i_snapshot - flattened result snapshot
//               i_size     - matrix dimension N (header payload)
//               i_row/i_col- element pointer
//               i_phase    - header / element / checksum
//               i_csum     - running checksum
//               o_byte     - selected byte
// Revision    : 1.0 - initial release
// ============================================================================
module frame_byte_sel
  import matrix_pkg::*;
#(
  parameter int MAX_SIZE   = MATRIX_MAX_SIZE,
  parameter int DATA_WIDTH = MATRIX_DATA_WIDTH
) (
  input  logic [MAX_SIZE*MAX_SIZE*DATA_WIDTH-1:0] i_snapshot,
  input  logic [3:0]                              i_size,
  input  logic [3:0]                              i_row,
  input  logic [3:0]                              i_col,
  input  frame_phase_t                            i_phase,
  input  logic [7:0]                              i_csum,
  output logic [7:0]                              o_byte
);

  localparam int C_ELEMS = MAX_SIZE * MAX_SIZE;
  localparam int C_IDX_W = $clog2(C_ELEMS);

  logic [DATA_WIDTH-1:0] w_elems [C_ELEMS];
  logic [C_IDX_W-1:0]    w_idx;

  for (genvar g = 0; g < C_ELEMS; g++) begin : g_elem
    assign w_elems[g] = i_snapshot[g*DATA_WIDTH +: DATA_WIDTH];
  end

  always_comb begin
    w_idx  = C_IDX_W'(i_row) * C_IDX_W'(MAX_SIZE) + C_IDX_W'(i_col);
    o_byte = '0;
    case (i_phase)
      PH_HEADER: o_byte = {4'b0000, i_size};
      // Guard keeps an out-of-range pointer from indexing past the array.
      PH_ELEM:   if (w_idx < C_IDX_W'(C_ELEMS)) o_byte = w_elems[w_idx];
      PH_CSUM:   o_byte = i_csum;
      default:   o_byte = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/result_frame_tx.sv
`default_nettype none
// ============================================================================
// Module      : result_frame_tx
// Description : UART response framer. Snapshots the result matrix on start
//               and streams size byte, N*N elements (row-major) and an
//               optional XOR checksum through the uart_tx start/busy
//               handshake.
// Ports       : clk, rst            - baud clock, async active-high reset
//               start               - one-cycle frame request (IDLE only)
//               matrix_size, result - N and flattened C matrix
//               tx_busy             - uart_tx busy
//               tx_start, tx_data   - byte request to uart_tx
//               busy, done, size_err- frame status
// Revision    : 1.0 - initial release
// ============================================================================
module result_frame_tx
  import matrix_pkg::*;
#(
  parameter int MAX_SIZE      = MATRIX_MAX_SIZE,
  parameter int DATA_WIDTH    = MATRIX_DATA_WIDTH,
  parameter bit SEND_CHECKSUM = FRAME_SEND_CHECKSUM
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic [3:0]                             matrix_size,
  input  logic [MAX_SIZE*MAX_SIZE*DATA_WIDTH-1:0] result,
  input  logic                                   tx_busy,
  output logic                                   tx_start,
  output logic [7:0]                             tx_data,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   size_err
);

  frame_state_t                          r_state;
  frame_state_t                          w_state_nxt;
  frame_phase_t                          r_phase;
  logic [MAX_SIZE*MAX_SIZE*DATA_WIDTH-1:0] r_snapshot;
  logic [3:0]                            r_size;
  logic [3:0]                            r_row;
  logic [3:0]                            r_col;
  logic [7:0]                            r_csum;
  logic                                  r_size_err;

  logic w_size_bad;
  logic w_last_col;
  logic w_last_row;
  logic w_last_byte;

  assign w_size_bad = (r_size == 4'd0) || ({28'd0, r_size} > 32'(MAX_SIZE));
  assign w_last_col = (r_col == r_size - 4'd1);
  assign w_last_row = (r_row == r_size - 4'd1);
  // Final byte is the checksum, or the last element when no checksum is sent.
  assign w_last_byte = (r_phase == PH_CSUM) ||
                       ((r_phase == PH_ELEM) && w_last_row && w_last_col && !SEND_CHECKSUM);

  frame_byte_sel #(
    .MAX_SIZE   (MAX_SIZE),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_byte_sel (
    .i_snapshot (r_snapshot),
    .i_size     (r_size),
    .i_row      (r_row),
    .i_col      (r_col),
    .i_phase    (r_phase),
    .i_csum     (r_csum),
    .o_byte     (tx_data)
  );

  assign size_err = r_size_err;

  always_comb begin
    w_state_nxt = r_state;
    tx_start    = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      ST_IDLE: if (start) w_state_nxt = ST_LOAD;
      ST_LOAD: begin
        busy = 1'b1;
        if (w_size_bad)    w_state_nxt = ST_FINISH;
        else if (!tx_busy) w_state_nxt = ST_SEND;
      end
      ST_SEND: begin
        busy        = 1'b1;
        tx_start    = 1'b1;
        w_state_nxt = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        busy = 1'b1;
        if (tx_busy) w_state_nxt = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        busy = 1'b1;
        if (!tx_busy) w_state_nxt = w_last_byte ? ST_FINISH : ST_SEND;
      end
      ST_FINISH: begin
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_phase    <= PH_HEADER;
      r_snapshot <= '0;
      r_size     <= '0;
      r_row      <= '0;
      r_col      <= '0;
      r_csum     <= '0;
      r_size_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_snapshot <= result;
            r_size     <= matrix_size;
            r_size_err <= 1'b0;
          end
        end
        ST_LOAD: begin
          r_phase <= PH_HEADER;
          r_row   <= '0;
          r_col   <= '0;
          r_csum  <= '0;
          if (w_size_bad) r_size_err <= 1'b1;
        end
        ST_SEND: begin
          if (r_phase != PH_CSUM) r_csum <= r_csum ^ tx_data;
        end
        ST_WAIT_DONE: begin
          if (!tx_busy && !w_last_byte) begin
            case (r_phase)
              PH_HEADER: r_phase <= PH_ELEM;
              PH_ELEM: begin
                if (w_last_col) begin
                  r_col <= '0;
                  if (w_last_row) r_phase <= PH_CSUM;
                  else            r_row   <= r_row + 4'd1;
                end else begin
                  r_col <= r_col + 4'd1;
                end
              end
              default: r_phase <= r_phase;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_result_frame_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_result_frame_tx
// Description : Scoreboard bench for result_frame_tx with a uart_tx busy
//               model. Stimulus queues expected bytes / done status; a
//               monitor pops and compares on every tx_start and done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_result_frame_tx;
  import matrix_pkg::*;

  localparam int N_MAX    = MATRIX_MAX_SIZE;
  localparam int BUS_W    = N_MAX * N_MAX * 8;
  localparam int BUSY_CYC = 10;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [3:0]       matrix_size = 4'd0;
  logic [BUS_W-1:0] result = '0;
  logic             tx_busy = 1'b0;
  logic             tx_start;
  logic [7:0]       tx_data;
  logic             busy;
  logic             done;
  logic             size_err;

  result_frame_tx #(
    .MAX_SIZE      (N_MAX),
    .DATA_WIDTH    (8),
    .SEND_CHECKSUM (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .matrix_size (matrix_size),
    .result      (result),
    .tx_busy     (tx_busy),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .busy        (busy),
    .done        (done),
    .size_err    (size_err)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_err = 0;
  int         tx_cnt = 0;
  int         done_cnt = 0;
  int         busy_cnt = 0;
  logic       force_busy = 1'b0;
  logic [7:0] exp_bytes[$];
  logic       exp_done[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // uart_tx model: busy for BUSY_CYC cycles after each tx_start
  initial forever begin
    @(negedge clk);
    if (tx_start === 1'b1) busy_cnt = BUSY_CYC;
    else if (busy_cnt > 0) busy_cnt--;
    tx_busy = force_busy || (busy_cnt > 0);
  end

  // Monitor / scoreboard
  initial forever begin
    @(negedge clk);
    if (tx_start === 1'b1) begin
      tx_cnt++;
      if (exp_bytes.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL byte_unexpected: got %02h expected none", tx_data);
      end else begin
        chk("tx_byte", 32'(tx_data), 32'(exp_bytes.pop_front()));
      end
    end
    if (done === 1'b1) begin
      done_cnt++;
      if (exp_done.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL done_unexpected: got done=1 expected none");
      end else begin
        chk("done_size_err", 32'(size_err), 32'(exp_done.pop_front()));
        chk("busy_at_done", 32'(busy), 32'd0);
      end
    end
  end

  task automatic pulse_start(input logic [3:0] n);
    @(negedge clk);
    matrix_size = n;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int limit, input string name);
    int k = 0;
    while (done_cnt < target && k < limit) begin
      @(negedge clk);
      k++;
    end
    if (done_cnt < target) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_done_timeout: got %0d expected %0d", name, done_cnt, target);
    end
  endtask

  task automatic wait_tx(input int target, input int limit, input string name);
    int k = 0;
    while (tx_cnt < target && k < limit) begin
      @(negedge clk);
      k++;
    end
    if (tx_cnt < target) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_tx_timeout: got %0d expected %0d", name, tx_cnt, target);
    end
  endtask

  task automatic set_pattern(input int n, input int seed);
    result = '0;
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++)
        result[(r*N_MAX+c)*8 +: 8] = 8'(seed + 7 * (r * N_MAX + c) + 1);
  endtask

  // Reference frame built from the bench's own copy of the result bus.
  task automatic push_model(input int n);
    logic [7:0] acc;
    logic [7:0] b;
    acc = 8'(n);
    exp_bytes.push_back(8'(n));
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++) begin
        b = result[(r*N_MAX+c)*8 +: 8];
        exp_bytes.push_back(b);
        acc = acc ^ b;
      end
    exp_bytes.push_back(acc);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int d0;
    logic [3:0] bad_n [2];
    bad_n[0] = 4'd0;
    bad_n[1] = 4'd11;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_tx_data",  32'(tx_data),  32'd0);
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_done",     32'(done),     32'd0);
    chk("rst_size_err", 32'(size_err), 32'd0);
    rst = 1'b0;

    // N=2 hand vector
    result = '0;
    result[0*8 +: 8]  = 8'h11;
    result[1*8 +: 8]  = 8'h22;
    result[10*8 +: 8] = 8'h33;
    result[11*8 +: 8] = 8'h44;
    exp_bytes.push_back(8'h02); exp_bytes.push_back(8'h11);
    exp_bytes.push_back(8'h22); exp_bytes.push_back(8'h33);
    exp_bytes.push_back(8'h44); exp_bytes.push_back(8'h46);
    exp_done.push_back(1'b0);
    base = tx_cnt; d0 = done_cnt;
    pulse_start(4'd2);
    chk("t1_busy", 32'(busy), 32'd1);
    wait_done(d0 + 1, 400, "t1");
    chk("t1_len", 32'(tx_cnt - base), 32'd6);

    // N=3, bus and size disturbed right after start
    result = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        result[(r*N_MAX+c)*8 +: 8] = 8'(r * 16 + c);
    exp_bytes.push_back(8'h03);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        exp_bytes.push_back(8'(r * 16 + c));
    exp_bytes.push_back(8'h30);
    exp_done.push_back(1'b0);
    base = tx_cnt; d0 = done_cnt;
    pulse_start(4'd3);
    result = '1;
    matrix_size = 4'd5;
    wait_done(d0 + 1, 600, "t2");
    chk("t2_len", 32'(tx_cnt - base), 32'd11);

    // Illegal sizes: no bytes, done two cycles after start, size_err held
    for (int i = 0; i < 2; i++) begin
      exp_done.push_back(1'b1);
      base = tx_cnt;
      @(negedge clk);
      matrix_size = bad_n[i];
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("bad_done_early", 32'(done), 32'd0);
      chk("bad_busy", 32'(busy), 32'd1);
      @(negedge clk);
      chk("bad_done", 32'(done), 32'd1);
      chk("bad_size_err", 32'(size_err), 32'd1);
      @(negedge clk);
      chk("bad_size_err_held", 32'(size_err), 32'd1);
      chk("bad_done_once", 32'(done), 32'd0);
      chk("bad_no_tx", 32'(tx_cnt - base), 32'd0);
    end

    // Second start mid-frame is ignored
    set_pattern(2, 40);
    push_model(2);
    exp_done.push_back(1'b0);
    base = tx_cnt; d0 = done_cnt;
    pulse_start(4'd2);
    wait_tx(base + 3, 200, "t4");
    set_pattern(4, 90);
    pulse_start(4'd4);
    wait_done(d0 + 1, 400, "t4");
    repeat (40) @(negedge clk);
    chk("t4_one_done", 32'(done_cnt - d0), 32'd1);
    chk("t4_len", 32'(tx_cnt - base), 32'd6);
    chk("t4_queue_empty", 32'(exp_bytes.size()), 32'd0);
    chk("t4_size_err", 32'(size_err), 32'd0);

    // tx_busy stuck high before the first byte
    force_busy = 1'b1;
    @(negedge clk);
    set_pattern(3, 3);
    push_model(3);
    exp_done.push_back(1'b0);
    base = tx_cnt; d0 = done_cnt;
    pulse_start(4'd3);
    repeat (500) @(negedge clk);
    chk("t5_no_tx", 32'(tx_cnt - base), 32'd0);
    chk("t5_busy", 32'(busy), 32'd1);
    force_busy = 1'b0;
    wait_done(d0 + 1, 600, "t5");
    chk("t5_len", 32'(tx_cnt - base), 32'd11);

    // Asynchronous reset during byte 4
    set_pattern(3, 17);
    push_model(3);
    exp_done.push_back(1'b0);
    base = tx_cnt;
    pulse_start(4'd3);
    wait_tx(base + 4, 300, "t6");
    repeat (3) @(negedge clk);
    chk("t6_busy_before", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_tx_start", 32'(tx_start), 32'd0);
    chk("t6_rst_tx_data",  32'(tx_data),  32'd0);
    chk("t6_rst_busy",     32'(busy),     32'd0);
    chk("t6_rst_done",     32'(done),     32'd0);
    chk("t6_rst_size_err", 32'(size_err), 32'd0);
    exp_bytes.delete();
    exp_done.delete();
    @(negedge clk);
    rst = 1'b0;
    set_pattern(3, 60);
    push_model(3);
    exp_done.push_back(1'b0);
    base = tx_cnt; d0 = done_cnt;
    pulse_start(4'd3);
    wait_done(d0 + 1, 600, "t6b");
    chk("t6_len", 32'(tx_cnt - base), 32'(frame_len(3, 1'b1)));
    chk("t6_queue_empty", 32'(exp_bytes.size()), 32'd0);

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
